// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode/funct codes,
// ALU select codes, PC source codes, instruction classes and FSM states.
package alu_issue_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLL  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_SLT  = 3'd6,
        ALU_SLTU = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP,
        CLS_NONE
    } op_class_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath-control bundle between the issue controller
// (master) and the memories/datapath (slave).
interface alu_issue_ctrl_if #(
    parameter int SEL_W = 6,
    parameter int CNT_W = 32
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             mem_ready;
    logic             zero_flag;
    logic             instr_req;
    logic             ir_write;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_src_b;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr_valid, instr, mem_ready, zero_flag,
        output instr_req, ir_write, alu_sel, alu_src_b, pc_write, pc_src,
               mem_read, mem_write, reg_write, mem_to_reg, illegal, retired
    );

    modport slave (
        output instr_valid, instr, mem_ready, zero_flag,
        input  instr_req, ir_write, alu_sel, alu_src_b, pc_write, pc_src,
               mem_read, mem_write, reg_write, mem_to_reg, illegal, retired
    );
endinterface

// File: rtl/alu_issue_ctrl_alu_op_decoder.sv
// Combinational opcode/funct classifier: instruction class, ALU operation,
// operand-B source and legality.
module alu_op_decoder
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_e  op_class,
    output alu_op_e    alu_sel,
    output logic       alu_src_b,
    output logic       legal
);

    // Table lookup; unknown opcodes and unknown R-type functs fall to CLS_NONE.
    always_comb begin
        op_class  = CLS_NONE;
        alu_sel   = ALU_ADD;
        alu_src_b = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                op_class = CLS_ALU;
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLL:  alu_sel = ALU_SLL;
                    FN_SRL:  alu_sel = ALU_SRL;
                    FN_SLT:  alu_sel = ALU_SLT;
                    FN_SLTU: alu_sel = ALU_SLTU;
                    default: op_class = CLS_NONE;
                endcase
            end
            OP_ADDI: begin op_class = CLS_ALU; alu_sel = ALU_ADD; alu_src_b = 1'b1; end
            OP_ANDI: begin op_class = CLS_ALU; alu_sel = ALU_AND; alu_src_b = 1'b1; end
            OP_ORI:  begin op_class = CLS_ALU; alu_sel = ALU_OR;  alu_src_b = 1'b1; end
            OP_SLTI: begin op_class = CLS_ALU; alu_sel = ALU_SLT; alu_src_b = 1'b1; end
            OP_LW:   op_class = CLS_LOAD;
            OP_SW:   op_class = CLS_STORE;
            OP_BEQ:  op_class = CLS_BEQ;
            OP_BNE:  op_class = CLS_BNE;
            OP_J:    op_class = CLS_JUMP;
            default: op_class = CLS_NONE;
        endcase
        legal = (op_class != CLS_NONE);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: fetches an instruction, decodes it, drives
// ALU/PC/register-file/data-memory controls and counts retired instructions.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int SEL_W = 6,
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             reset_n,
    alu_issue_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [5:0]       opcode_q, funct_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    op_class_e dec_class;
    alu_op_e   dec_alu;
    logic      dec_src_b;
    logic      dec_legal;

    logic    instr_req, ir_write, alu_src_b, pc_write;
    logic    mem_read, mem_write, reg_write, mem_to_reg, illegal;
    alu_op_e alu_op;
    pc_src_e pc_src;
    logic    take_branch;

    // Only opcode and funct are consumed here; the rest belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:6];

    alu_op_decoder u_dec (
        .opcode    (opcode_q),
        .funct     (funct_q),
        .op_class  (dec_class),
        .alu_sel   (dec_alu),
        .alu_src_b (dec_src_b),
        .legal     (dec_legal)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    // Capture opcode/funct when the fetched word is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= '0;
            funct_q  <= '0;
        end else if (state_q == ST_FETCH && bus.instr_valid) begin
            opcode_q <= bus.instr[31:26];
            funct_q  <= bus.instr[5:0];
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    retired_q <= '0;
        else if (retire) retired_q <= retired_q + CNT_W'(1);
    end

    assign take_branch = (dec_class == CLS_BEQ &&  bus.zero_flag) ||
                         (dec_class == CLS_BNE && !bus.zero_flag);

    // Next-state and control decode. ir_write/pc_write in FETCH follow
    // instr_valid so the PC only advances when a word is actually taken.
    always_comb begin
        state_d    = state_q;
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req = 1'b1;
                if (bus.instr_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                illegal = !dec_legal;
                case (dec_class)
                    CLS_ALU:            state_d = ST_EXEC;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:   state_d = ST_BRANCH;
                    CLS_JUMP:           state_d = ST_JUMP;
                    default:            state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                alu_op    = dec_alu;
                alu_src_b = dec_src_b;
                state_d   = ST_WB;
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_b = 1'b1;
                state_d   = (dec_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read  = 1'b1;
                alu_src_b = 1'b1;
                if (bus.mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                alu_src_b = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                alu_op = ALU_SUB;
                if (take_branch) begin
                    pc_write = 1'b1;
                    pc_src   = PC_BRANCH;
                end
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.instr_req  = instr_req;
    assign bus.ir_write   = ir_write;
    assign bus.alu_sel    = SEL_W'(alu_op);
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal;
    assign bus.retired    = retired_q;

endmodule
